// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-stage status in, sequencing/forwarding controls out, for the hazard controller.
// master = datapath side, slave = controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int WORD_SIZE  = 16,
  parameter int REG_ADDR_W = 2
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  id_is_jump;
  logic                  id_is_jreg;
  logic                  id_is_halt;
  logic                  ex_valid;
  logic                  ex_mem_read;
  logic                  ex_reg_write;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  ex_branch_taken;
  logic                  mem_valid;
  logic                  mem_mem_read;
  logic                  mem_reg_write;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  wb_valid;
  logic                  wb_reg_write;
  logic                  wb_is_halt;
  logic [REG_ADDR_W-1:0] wb_rd;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  readM1;
  logic [WORD_SIZE-1:0]  num_inst;
  logic                  is_halted;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_jump, id_is_jreg,
           id_is_halt, ex_valid, ex_mem_read, ex_reg_write, ex_rd, ex_rs, ex_rt,
           ex_branch_taken, mem_valid, mem_mem_read, mem_reg_write, mem_rd,
           wb_valid, wb_reg_write, wb_is_halt, wb_rd,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
           readM1, num_inst, is_halted
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_jump, id_is_jreg,
           id_is_halt, ex_valid, ex_mem_read, ex_reg_write, ex_rd, ex_rs, ex_rt,
           ex_branch_taken, mem_valid, mem_mem_read, mem_reg_write, mem_rd,
           wb_valid, wb_reg_write, wb_is_halt, wb_rd,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
           readM1, num_inst, is_halted
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush/forwarding controller for the 5-stage 16-bit pipeline, with halt
// drain FSM and retired-instruction counter. Reset_N is active-high, synchronous.
module pipeline_hazard_ctrl #(
  parameter int WORD_SIZE  = 16,
  parameter int REG_ADDR_W = 2
) (
  input logic                    Clk,
  input logic                    Reset_N,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t                state_q, state_nx;
  logic [WORD_SIZE-1:0]  num_inst_q;
  logic                  is_halted_q;
  logic                  lu_hazard, jr_hazard;
  logic                  pc_write, if_id_write, if_id_flush, id_ex_bubble, read_m1;
  logic [1:0]            fwd_a, fwd_b;

  always_ff @(posedge Clk) begin
    if (Reset_N) begin
      state_q     <= S_RUN;
      num_inst_q  <= '0;
      is_halted_q <= 1'b0;
    end else begin
      state_q     <= state_nx;
      // HLT's own retirement counts, since is_halted only rises the cycle after
      if (hz.wb_valid && !is_halted_q)
        num_inst_q <= num_inst_q + WORD_SIZE'(1);
      is_halted_q <= (state_nx == S_HALTED);
    end
  end

  always_comb begin
    lu_hazard = hz.id_valid & hz.ex_valid & hz.ex_mem_read & hz.ex_reg_write &
                ((hz.id_uses_rs & (hz.id_rs == hz.ex_rd)) |
                 (hz.id_uses_rt & (hz.id_rt == hz.ex_rd)));
    // register jumps read rs in ID, where no forwarding path exists
    jr_hazard = hz.id_valid & hz.id_is_jreg &
                ((hz.ex_valid & hz.ex_reg_write & (hz.ex_rd == hz.id_rs)) |
                 (hz.mem_valid & hz.mem_mem_read & (hz.mem_rd == hz.id_rs)));
  end

  always_comb begin
    state_nx     = state_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    read_m1      = 1'b0;
    if (Reset_N) begin
      if_id_flush = 1'b1;
      state_nx    = S_RUN;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (hz.ex_branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            read_m1      = 1'b1;
          end else if (lu_hazard || jr_hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            read_m1      = 1'b1;
          end else if (hz.id_is_jump) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b0;
            read_m1      = 1'b1;
          end else if (hz.id_is_halt) begin
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b0;
            state_nx     = S_DRAIN;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
            read_m1      = 1'b1;
          end
        end
        S_DRAIN: begin
          if (hz.wb_valid && hz.wb_is_halt)
            state_nx = S_HALTED;
        end
        S_HALTED: state_nx = S_HALTED;
        default:  state_nx = S_RUN;
      endcase
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!Reset_N) begin
      if (hz.mem_valid && hz.mem_reg_write && !hz.mem_mem_read && (hz.mem_rd == hz.ex_rs))
        fwd_a = 2'b01;
      else if (hz.wb_valid && hz.wb_reg_write && (hz.wb_rd == hz.ex_rs))
        fwd_a = 2'b10;
      if (hz.mem_valid && hz.mem_reg_write && !hz.mem_mem_read && (hz.mem_rd == hz.ex_rt))
        fwd_b = 2'b01;
      else if (hz.wb_valid && hz.wb_reg_write && (hz.wb_rd == hz.ex_rt))
        fwd_b = 2'b10;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.fwd_a        = fwd_a;
  assign hz.fwd_b        = fwd_b;
  assign hz.readM1       = read_m1;
  assign hz.num_inst     = num_inst_q;
  assign hz.is_halted    = is_halted_q;

endmodule
